// File: rtl/xor_gate_bist.sv
// xor_gate_bist: built-in self-test sequencer for a two-input XOR gate.
// On a start request it walks the gate through 00,10,01,11 (as a,b),
// holds each vector for SETTLE_CYCLES clocks, samples gate_c and
// accumulates a per-vector failure mask, a saturating error count and
// a pass flag. REPEAT full passes are made per run.
module xor_gate_bist #(
  parameter int SETTLE_CYCLES = 4,
  parameter int REPEAT        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_c,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [ERR_W-1:0] err_count
);

  // Counter widths; a one-cycle settle or single pass still needs one bit.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    LAST_PASS   = PW'(REPEAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Vector index i drives a = i[0], b = i[1]: 0->00, 1->10, 2->01, 3->11.
  function automatic logic f_vec_a(input logic [1:0] idx);
    return idx[0];
  endfunction

  function automatic logic f_vec_b(input logic [1:0] idx);
    return idx[1];
  endfunction

  // Expected XOR output for vector index i.
  function automatic logic f_expected(input logic [1:0] idx);
    return idx[0] ^ idx[1];
  endfunction

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [PW-1:0]    r_pass_cnt;
  logic [SW-1:0]    r_settle;
  logic             r_gate_a;
  logic             r_gate_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_fail_mask;
  logic [ERR_W-1:0] r_err_count;

  state_t           w_state_nxt;
  logic             w_sample;
  logic             w_last;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;
  logic [1:0]       w_idx_nxt;
  logic [PW-1:0]    w_pass_cnt_nxt;
  logic [SW-1:0]    w_settle_nxt;
  logic             w_gate_a_nxt;
  logic             w_gate_b_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pass_nxt;
  logic [3:0]       w_fail_mask_nxt;
  logic [ERR_W-1:0] w_err_count_nxt;

  assign w_sample = (r_state == S_DRIVE) && (r_settle == {SW{1'b0}});
  assign w_last   = w_sample && (r_idx == 2'd3) && (r_pass_cnt == LAST_PASS);

  // Compare gate_c with the expected bit; an unknown gate_c falls into the mismatch branch.
  always_comb begin
    w_mismatch = 1'b1;
    if (gate_c == f_expected(r_idx)) begin
      w_mismatch = 1'b0;
    end else begin
      w_mismatch = 1'b1;
    end
  end

  // Saturating increment of the error count.
  always_comb begin
    w_err_inc = r_err_count;
    if (r_err_count == ERR_MAX) begin
      w_err_inc = r_err_count;
    end else begin
      w_err_inc = r_err_count + ERR_W'(1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; all outputs are registered below.
  always_comb begin
    w_idx_nxt       = r_idx;
    w_pass_cnt_nxt  = r_pass_cnt;
    w_settle_nxt    = r_settle;
    w_gate_a_nxt    = r_gate_a;
    w_gate_b_nxt    = r_gate_b;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_pass_nxt      = r_pass;
    w_fail_mask_nxt = r_fail_mask;
    w_err_count_nxt = r_err_count;
    case (r_state)
      S_IDLE: begin
        w_gate_a_nxt = 1'b0;
        w_gate_b_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        if (start) begin
          w_idx_nxt       = 2'd0;
          w_pass_cnt_nxt  = {PW{1'b0}};
          w_settle_nxt    = SETTLE_LOAD;
          w_fail_mask_nxt = 4'b0000;
          w_err_count_nxt = {ERR_W{1'b0}};
          w_pass_nxt      = 1'b0;
          w_busy_nxt      = 1'b1;
          w_gate_a_nxt    = f_vec_a(2'd0);
          w_gate_b_nxt    = f_vec_b(2'd0);
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_DRIVE: begin
        if (w_sample) begin
          if (w_mismatch) begin
            w_fail_mask_nxt[r_idx] = 1'b1;
            w_err_count_nxt        = w_err_inc;
          end else begin
            w_err_count_nxt = r_err_count;
          end
          w_idx_nxt    = r_idx + 2'd1;
          w_settle_nxt = SETTLE_LOAD;
          if (r_idx == 2'd3) begin
            w_pass_cnt_nxt = r_pass_cnt + PW'(1'b1);
          end else begin
            w_pass_cnt_nxt = r_pass_cnt;
          end
          if (w_last) begin
            w_gate_a_nxt = 1'b0;
            w_gate_b_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_pass_nxt   = (w_err_count_nxt == {ERR_W{1'b0}});
          end else begin
            w_gate_a_nxt = f_vec_a(r_idx + 2'd1);
            w_gate_b_nxt = f_vec_b(r_idx + 2'd1);
          end
        end else begin
          w_settle_nxt = r_settle - SW'(1'b1);
        end
      end
      S_DONE: begin
        w_gate_a_nxt = 1'b0;
        w_gate_b_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
      default: begin
        w_gate_a_nxt = 1'b0;
        w_gate_b_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears results and abandons a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 2'd0;
      r_pass_cnt  <= {PW{1'b0}};
      r_settle    <= {SW{1'b0}};
      r_gate_a    <= 1'b0;
      r_gate_b    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= 4'b0000;
      r_err_count <= {ERR_W{1'b0}};
    end else begin
      r_idx       <= w_idx_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
      r_settle    <= w_settle_nxt;
      r_gate_a    <= w_gate_a_nxt;
      r_gate_b    <= w_gate_b_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_mask <= w_fail_mask_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign gate_a    = r_gate_a;
  assign gate_b    = r_gate_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
  assign err_count = r_err_count;

endmodule

// File: doc/xor_gate_bist.md
# xor_gate_bist

Built-in self-test sequencer for the two-input XOR gate (`XORGate_`, ports `a`, `b`, `c`). On a start request it drives the gate through its full truth table: 00, 10, 01, 11, in that order. It waits a programmable settle time per vector, samples the gate output and checks it against `a ^ b`. It reports pass/fail, a per-vector failure mask and a saturating error count. It sits between the test/config logic and the gate instance, and owns the gate's inputs while running.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles each vector is held before `gate_c` is sampled. Legal range is ≥1.
- `REPEAT`, default 1: number of full passes over the four vectors per run. Legal range is ≥1.
- `ERR_W`, default 8: width of `err_count`.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: run request; sampled only in IDLE.
- `gate_c`, input, 1: output of the gate under test.
- `gate_a`, output, 1: drives gate input `a`.
- `gate_b`, output, 1: drives gate input `b`.
- `busy`, output, 1: high while a run is in progress.
- `done`, output, 1: one-cycle pulse when a run completes.
- `pass`, output, 1: result of the last completed run; 1 when no mismatches.
- `fail_mask`, output, 4: bit i is set if vector i mismatched in any pass. Vector 0 = 00, 1 = 10, 2 = 01, 3 = 11, written as (a,b).
- `err_count`, output, `ERR_W`: total mismatches in the last run, saturating at all-ones.

## Operation
- There is one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset forces state IDLE and drives every output to 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `fail_mask`, `err_count`.
- FSM states are IDLE, DRIVE and DONE.
- IDLE:
  - `gate_a` and `gate_b` are 0.
  - On `start`=1, at the edge:
    - go to DRIVE;
    - load vector index 0 and pass counter 0;
    - load settle counter `SETTLE_CYCLES-1`;
    - clear `fail_mask`, `err_count` and `pass`;
    - set `busy`=1.
- DRIVE:
  - `gate_a`/`gate_b` present the current vector, registered.
  - Each edge with settle counter ≠ 0 decrements it.
  - At the edge where the settle counter = 0:
    - compare `gate_c` against the vector's expected value (0,1,1,0 for vectors 0..3);
    - on a mismatch, set `fail_mask[idx]` and increment `err_count`, saturating;
    - an X or Z on `gate_c` counts as a mismatch;
    - advance the index (3 wraps to 0, and the pass counter increments);
    - reload the settle counter.
- After the sample of vector 3 on pass `REPEAT-1`:
  - go to DONE;
  - `gate_a`/`gate_b` return to 0;
  - `pass` is set to 1 if and only if the final `err_count` is 0, counting the mismatch from this last sample.
- DONE lasts exactly one cycle, with `done`=1 and `busy`=0, then the FSM returns to IDLE.
- `pass`, `fail_mask` and `err_count` hold until the next accepted `start` or reset.
- `start` while in DRIVE or DONE is ignored; it is not queued.
- If `rst` is asserted mid-run, the run is abandoned: state goes to IDLE and all outputs are 0 on the next cycle, with no `done` pulse.

## Timing
- Accept edge E0 is the edge at which `start`=1 is sampled in IDLE.
- From E0, `busy`=1 and vector 0 is on `gate_a`/`gate_b`.
- Vector k of the run (k = 0..4·REPEAT−1) is sampled at edge E0 + (k+1)·SETTLE_CYCLES; the next vector appears at that same edge.
- `done`=1 in the cycle following E0 + 4·REPEAT·SETTLE_CYCLES.
- Total latency from the accept edge to the done cycle is 4·REPEAT·SETTLE_CYCLES cycles. For the defaults this is 16 cycles.
- `busy` falls at the same edge at which `done` rises.
- `gate_c` must be stable for the last cycle before each sample edge.
- Earliest restart: `start` sampled at the edge after the DONE cycle.

## Test plan
- **Defaults, correct XOR gate:**
  - stimulus: reset, then pulse `start`;
  - response: `gate_a`/`gate_b` sequence 00,10,01,11, each held 4 cycles;
  - `done` arrives 16 cycles after the accept edge;
  - `pass`=1, `fail_mask`=0000, `err_count`=0.
- **Stuck-at-0 output:**
  - stimulus: `gate_c` tied to 0;
  - response: `fail_mask`=0110, `err_count`=2, `pass`=0.
- **OR gate substituted, REPEAT=3:**
  - response: `fail_mask`=1000, `err_count`=3;
  - `done` arrives 48 cycles after accept.
- **SETTLE_CYCLES=1:**
  - response: the vector changes on every edge;
  - `done` arrives 4 cycles after accept;
  - results match the default case.
- **Start handling:**
  - stimulus: `start` held high for an entire run;
  - response: no restart until IDLE;
  - with `start` still high, a second run begins at the edge after DONE and results are cleared.
- **Reset mid-run and saturation:**
  - stimulus: `rst` at vector 2;
  - response: next cycle all outputs are 0 and there is no `done`.
  - stimulus: inverted gate with ERR_W=2, REPEAT=1;
  - response: `err_count` saturates at 3 while 4 mismatches occur;
  - `fail_mask`=1111, `pass`=0.
